// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states,
// and the alignment rule.
package mem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    RMW_RD,
    ST_DONE,
    ERR
  } state_e;

  // Illegal size or natural-alignment violation; such requests never touch RAM.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: extract/extend a sub-word from a RAM word for loads,
// and merge right-aligned store data into a RAM word for read-modify-write.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);

  logic [4:0]        shamt_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] mask_c;

  always_comb begin
    // Halfwords sit on 16-bit lanes, so only addr_lo[1] selects them.
    shamt_c   = (size == SIZE_H) ? {addr_lo[1], 4'b0000} : {addr_lo, 3'b000};
    shifted_c = rd_word >> shamt_c;
    ld_data   = shifted_c;
    mask_c    = '1;
    case (size)
      SIZE_B: begin
        ld_data = {{24{sign_ext & shifted_c[7]}}, shifted_c[7:0]};
        mask_c  = DATA_W'(32'h0000_00FF) << shamt_c;
      end
      SIZE_H: begin
        ld_data = {{16{sign_ext & shifted_c[15]}}, shifted_c[15:0]};
        mask_c  = DATA_W'(32'h0000_FFFF) << shamt_c;
      end
      default: ;
    endcase
    st_word = (rd_word & ~mask_c) | ((wdata << shamt_c) & mask_c);
  end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store front end for a word-addressed single-port synchronous RAM:
// sub-word loads with extension, sub-word stores as read-modify-write.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] ld_data_c;
  logic [DATA_W-1:0] st_word_c;

  mem_lane u_lane (
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sext_q),
    .rd_word  (ram_dout),
    .wdata    (wdata_q),
    .ld_data  (ld_data_c),
    .st_word  (st_word_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM strobes are issued in the acceptance cycle, so they decode straight
  // from the live request while IDLE and from latched fields afterwards.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    sext_d   = sext_q;
    rdata_d  = rdata_q;
    ready    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    rdata    = rdata_q;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_din  = '0;
    ram_addr = addr_q[ADDR_W-1:2];

    case (state_q)
      IDLE: begin
        ready    = 1'b1;
        ram_addr = addr[ADDR_W-1:2];
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = size;
          sext_d  = sign_ext;
          if (is_illegal(size, addr[1:0])) begin
            state_d = ERR;
          end else if (!we) begin
            ram_re  = 1'b1;
            state_d = LD_WAIT;
          end else if (size == SIZE_W) begin
            ram_we  = 1'b1;
            ram_din = wdata;
            state_d = ST_DONE;
          end else begin
            ram_re  = 1'b1;
            state_d = RMW_RD;
          end
        end
      end
      LD_WAIT: begin
        done    = 1'b1;
        rdata   = ld_data_c;
        rdata_d = ld_data_c;
        state_d = IDLE;
      end
      RMW_RD: begin
        ram_we  = 1'b1;
        ram_din = st_word_c;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Load/store front end sitting directly upstream of the word-addressed, single-port synchronous RAM (30-bit word address, 32-bit data, separate re/we, registered dout, 1-cycle read latency, no byte enables).
- Accepts byte-addressed CPU load/store requests of byte, halfword or word size.
- Performs sign/zero extension on loads.
- Implements sub-word stores as read-modify-write sequences.
- Flags misaligned accesses without touching RAM.

Parameters:
- ADDR_W, 32, CPU byte-address width; RAM word address is ADDR_W-2 bits (30).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request valid; sampled only when ready=1.
- ready  out  1  block idle and able to accept a request.
- we  in  1  1=store, 0=load.
- size  in  2  access size: 00=byte, 01=half, 10=word; 11=illegal.
- sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- done  out  1  one-cycle pulse marking completion.
- rdata  out  32  load result, valid while done=1; holds its value otherwise.
- err  out  1  valid with done; 1=misaligned or illegal size, no RAM access made.
- ram_addr  out  30  word address to RAM (addr[31:2]).
- ram_din  out  32  write data to RAM.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM read data, valid the cycle after ram_re.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, done=0, err=0, rdata=0, ram_re=0, ram_we=0.
  - Internal latched address, data, size and sign_ext registers are cleared to 0.
- Reset mid-operation aborts the operation. No RAM write is issued after rst_n falls, and no done pulse is produced for the aborted request.
- Request fields are latched on acceptance (req&ready). They may change afterwards without effect.
- Alignment check:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size=11 is always illegal.
- State machine:
  - IDLE: ready=1. On req:
    - illegal -> ERR.
    - load -> LD_WAIT, asserting ram_re in the acceptance cycle.
    - word store -> ST_DONE, asserting ram_we with ram_din=wdata in the acceptance cycle.
    - sub-word store -> RMW_RD, asserting ram_re in the acceptance cycle.
    - ram_addr is driven combinationally from addr in IDLE and from the latched address otherwise.
  - LD_WAIT: select lane from ram_dout using latched addr[1:0]:
    - byte lane = addr[1:0]*8.
    - half lane = addr[1]*16.
    - extend per sign_ext into rdata.
    - done=1, -> IDLE.
  - RMW_RD: merge latched wdata into ram_dout:
    - byte replaces bits [8*a+7:8*a].
    - half replaces bits [16*a1+15:16*a1].
    - drive ram_we=1 with the merged word this cycle. -> ST_DONE.
  - ST_DONE: done=1, err=0, -> IDLE.
  - ERR: done=1, err=1, rdata unchanged, -> IDLE.
- Outputs outside IDLE:
  - ready=0 in every non-IDLE state.
  - ram_re and ram_we are never asserted together.
  - Neither is asserted in ERR or ST_DONE.
- Latencies (acceptance = cycle 0):
  - load done in cycle 1.
  - word store done in cycle 1.
  - sub-word store write in cycle 1, done in cycle 2.
  - error done in cycle 1.
- Back-to-back: a new request may be accepted in the cycle after done (the IDLE cycle). A load immediately following a store to the same word returns the stored value.
- Store data: wdata upper bits beyond the access size are ignored.
- Address width: addr[31:2] is passed unmodified as ram_addr. The RAM's internal address wrap is not the block's concern.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_B/SIZE_H/SIZE_W.
  - state encoding enum (IDLE, LD_WAIT, RMW_RD, ST_DONE, ERR).
- One natural sub-module, mem_lane: purely combinational lane extract/extend (load path) and lane merge (store path) from addr[1:0], size and sign_ext. It is reused by the FSM top.

Test Plan:
- RAM word 0x10 preloaded 0x8899AABB. Load byte addr 0x41 sign_ext=1 -> rdata=0xFFFFFFAA, done at cycle 1. Same with sign_ext=0 -> 0x000000AA.
- Load half addr 0x42 sign_ext=1 on that word -> rdata=0xFFFF8899. Load word addr 0x40 -> rdata=0x8899AABB.
- Store byte 0x5A to addr 0x43 on that word:
  - ram_re at cycle 0.
  - ram_we with ram_din=0x5A99AABB at cycle 1.
  - done at cycle 2.
  - A following word load returns 0x5A99AABB.
- Store word 0xDEADBEEF to addr 0x40 -> single ram_we cycle 0, done cycle 1, no ram_re.
- Misaligned accesses:
  - Half load at addr 0x41 -> done+err at cycle 1, ram_re/ram_we never asserted.
  - Word store at addr 0x42 -> same.
  - size=11 -> same.
- Reset mid-operation: rst_n dropped during RMW_RD of a byte store -> no ram_we, no done, and immediately after reset ready=1, rdata=0.
